din_capture_ctrl: RTL
=====================

Name: din_capture_ctrl

Overview:
- Sequencer for a din-sampling DFF bank inside the capture hierarchy.
- On a start request it waits a programmable delay, then captures din into a sample vector for a programmable number of consecutive clock cycles.
- It then reports completion with a one-cycle done pulse.
- It provides the single point of control for arming, windowing and reading back din captures.

Parameters:
- DEPTH, 8, maximum number of captured samples (width of sample_vec); legal range 1..32.
- DLY_W, 4, width of cfg_delay; maximum pre-capture delay is 2^DLY_W-1 cycles.
- LEN_W, 4, width of cfg_len; must satisfy 2^LEN_W-1 >= DEPTH.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a capture run; honoured only in IDLE.
- abort  input  1  cancel a run in progress; returns to IDLE without done.
- cfg_delay  input  DLY_W  cycles to wait between start acceptance and the first capture.
- cfg_len  input  LEN_W  number of samples; 0 or values above DEPTH mean DEPTH.
- din  input  1  data being captured.
- capt_en  output  1  high in every cycle whose rising edge at the end samples din.
- busy  output  1  high in DELAY and CAPTURE.
- done  output  1  one-cycle pulse when a run completes normally.
- sample_vec  output  DEPTH  captured bits; bit i = i-th sample; unused upper bits are 0.
- sample_cnt  output  LEN_W  number of samples captured in the last or current run.

Behaviour:
- Reset (rst=1 at a posedge): state=IDLE, capt_en=0, busy=0, done=0, sample_vec=0, sample_cnt=0, internal counters=0. Reset overrides start and abort in the same cycle, and reset mid-run discards the run.
- State machine has four states: IDLE, DELAY, CAPTURE, DONE.
- IDLE:
  - start=1 latches cfg_delay and the effective length (clamped to DEPTH).
  - It also clears sample_vec and sample_cnt.
  - Next state is DELAY if the latched delay is greater than 0, otherwise CAPTURE.
  - cfg_* are ignored outside the acceptance cycle; changing them mid-run has no effect.
- DELAY: the delay counter counts down from the latched value. On reaching 1, next state is CAPTURE. Exactly cfg_delay cycles are spent in DELAY.
- CAPTURE:
  - capt_en=1.
  - Each posedge writes din into sample_vec[sample_cnt] and increments sample_cnt.
  - After the posedge that stores the last sample (sample_cnt reaching the latched length), next state is DONE.
  - Exactly len cycles are spent in CAPTURE.
- DONE: done=1 for exactly one cycle; busy=0, capt_en=0. Next state is always IDLE. start is ignored in DONE.
- Latency: with start accepted at posedge T and delay D, the first sample is taken at posedge T+1+D and done is high in the cycle after the last sample.
- Total cycles from acceptance to done-high is D+L.
- abort:
  - Honoured in DELAY or CAPTURE; next state is IDLE and no done pulse is issued.
  - sample_vec and sample_cnt keep the partial capture.
  - If abort coincides with the final capture edge, abort wins: that last sample is still stored, but done is suppressed.
  - abort is ignored in IDLE and DONE.
- start while busy is ignored (no queueing).
- sample_vec and sample_cnt hold their values until the next accepted start or reset.
- Counters are unsigned, and the delay counter never wraps (it stops at the transition).

Optional Feature:
- Macro: CAPT_STUCK_DETECT_EN.
- When defined:
  - Adds output stuck (1 bit) and output stuck_val (1 bit).
  - In the DONE cycle, stuck=1 if all L samples of the run are equal; stuck_val then equals that value.
  - stuck is registered, held until the next accepted start or reset, and reset to 0.
  - An aborted run leaves stuck=0.
- When undefined: the ports and logic are absent, and the rest of the behaviour is identical.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, DELAY, CAPTURE, DONE, 2-bit encoding);
  - DEPTH_MAX=32;
  - a length-clamp function (0 or >DEPTH -> DEPTH).
- One natural sub-module: capt_delay_cnt. It is a loadable down-counter with load, enable and a zero/terminal flag, used for the DELAY phase.
- The FSM and sample register stay in the top module.

Test Plan:
- Basic run: DEPTH=8, cfg_delay=0, cfg_len=4, start pulse, din=1,0,1,1 on the capture edges. Required: capt_en high 4 cycles starting the cycle after start; sample_vec=8'b0000_1101; sample_cnt=4; done pulses once in the next cycle.
- Delay plus clamp: cfg_delay=3, cfg_len=0, din held 1. Required: 3 busy cycles with capt_en=0, then 8 capture cycles; sample_vec=8'hFF; done exactly 11 cycles after the start acceptance edge. With CAPT_STUCK_DETECT_EN: stuck=1, stuck_val=1.
- Abort mid-capture: cfg_len=6, abort asserted after 3 samples (din=0,1,0). Required: next cycle IDLE, no done pulse, sample_vec=8'b0000_0010, sample_cnt=3, stuck=0.
- Start while busy and cfg change: second start plus new cfg_len=2 issued during CAPTURE of a len=5 run. Required: run completes with 5 samples and only one done pulse; cfg change is ignored.
- Reset mid-DELAY: rst=1 for 1 cycle during DELAY with start=1 also high. Required: all outputs 0 the next cycle; state IDLE; a later start begins a fresh run normally.
- Abort on last edge: cfg_len=2, abort coincident with the 2nd capture edge. Required: sample_cnt=2, done stays 0.

Source files
------------

// File: rtl/din_capture_ctrl_pkg.sv
// Shared types and helpers for the din capture sequencer: state encoding,
// the absolute depth ceiling and the capture-length clamp.
package din_capture_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DELAY   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int DEPTH_MAX = 32;

    // A requested length of 0, or one beyond the bank, means a full-depth capture.
    function automatic int clamp_len(input int len, input int depth);
        return ((len == 0) || (len > depth)) ? depth : len;
    endfunction

endpackage

// File: rtl/din_capture_ctrl_delay_cnt.sv
// Loadable down-counter that times the pre-capture delay; it stops at zero
// and flags the last counted cycle (count == 1).
module capt_delay_cnt #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic         i_en,
    input  logic [W-1:0] i_val,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_tc = (r_cnt == W'(1));

endmodule

// File: rtl/din_capture_ctrl.sv
// Sequencer for the din-sampling DFF bank: arm, wait, capture a window, pulse done.
// Optional CAPT_STUCK_DETECT_EN adds a stuck-sample flag and its value.
//
// state   | meaning
// IDLE    | waiting for start; sample_vec/sample_cnt hold last run
// DELAY   | pre-capture wait, delay counter running
// CAPTURE | capt_en high, one din sample stored per edge
// DONE    | one-cycle done pulse, then back to IDLE
module din_capture_ctrl
    import din_capture_ctrl_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DLY_W = 4,
    parameter int LEN_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [DLY_W-1:0] i_cfg_delay,
    input  logic [LEN_W-1:0] i_cfg_len,
    input  logic             i_din,
    output logic             o_capt_en,
    output logic             o_busy,
    output logic             o_done,
    output logic [DEPTH-1:0] o_sample_vec,
    output logic [LEN_W-1:0] o_sample_cnt
`ifdef CAPT_STUCK_DETECT_EN
    ,
    output logic             o_stuck,
    output logic             o_stuck_val
`endif
);

    state_t             r_state;
    state_t             w_next;
    logic [LEN_W-1:0]   r_len;
    logic [DEPTH-1:0]   r_sample_vec;
    logic [LEN_W-1:0]   r_sample_cnt;
    logic               w_accept;
    logic               w_cnt_load;
    logic               w_cnt_en;
    logic               w_dly_tc;
    logic               w_last;
    logic               w_capt_en;
    logic               w_busy;
    logic               w_done;

    capt_delay_cnt #(.W(DLY_W)) u_dly_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_cnt_load),
        .i_en   (w_cnt_en),
        .i_val  (i_cfg_delay),
        .o_tc   (w_dly_tc)
    );

    // True in the capture cycle whose closing edge stores the final sample.
    assign w_last = (r_sample_cnt == (r_len - LEN_W'(1)));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_cnt_load = 1'b0;
        w_cnt_en   = 1'b0;
        w_capt_en  = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_accept   = 1'b1;
                    w_cnt_load = 1'b1;
                    w_next     = (i_cfg_delay != '0) ? ST_DELAY : ST_CAPTURE;
                end
            end
            ST_DELAY: begin
                w_busy   = 1'b1;
                w_cnt_en = 1'b1;
                if (i_abort) begin
                    w_next = ST_IDLE;
                end else if (w_dly_tc) begin
                    w_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_busy    = 1'b1;
                w_capt_en = 1'b1;
                if (i_abort) begin
                    w_next = ST_IDLE;
                end else if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // An abort in CAPTURE still keeps the sample taken on that edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_len        <= '0;
            r_sample_vec <= '0;
            r_sample_cnt <= '0;
        end else if (w_accept) begin
            r_len        <= LEN_W'(clamp_len(int'(i_cfg_len), DEPTH));
            r_sample_vec <= '0;
            r_sample_cnt <= '0;
        end else if (w_capt_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_sample_cnt == LEN_W'(i)) begin
                    r_sample_vec[i] <= i_din;
                end
            end
            r_sample_cnt <= r_sample_cnt + LEN_W'(1);
        end
    end

    assign o_capt_en    = w_capt_en;
    assign o_busy       = w_busy;
    assign o_done       = w_done;
    assign o_sample_vec = r_sample_vec;
    assign o_sample_cnt = r_sample_cnt;

`ifdef CAPT_STUCK_DETECT_EN
    logic r_all1;
    logic r_all0;
    logic r_stuck;
    logic r_stuck_val;

    // Running all-ones / all-zeros flags let the verdict land on the DONE entry edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_all1      <= 1'b0;
            r_all0      <= 1'b0;
            r_stuck     <= 1'b0;
            r_stuck_val <= 1'b0;
        end else if (w_accept) begin
            r_all1      <= 1'b1;
            r_all0      <= 1'b1;
            r_stuck     <= 1'b0;
            r_stuck_val <= 1'b0;
        end else if (w_capt_en) begin
            r_all1 <= r_all1 & i_din;
            r_all0 <= r_all0 & ~i_din;
            if (w_next == ST_DONE) begin
                r_stuck     <= (r_all1 & i_din) | (r_all0 & ~i_din);
                r_stuck_val <= i_din;
            end
        end
    end

    assign o_stuck     = r_stuck;
    assign o_stuck_val = r_stuck_val;
`endif

endmodule
